pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MD_LATENCY, default 32: execute-stage cycles occupied by one mult/div, legal range 2..64.
REQ-002 Parameter LW_OP, default 5'b01000: load-word opcode.
REQ-003 Parameter OP_RTYPE, default 5'b00000: R-type opcode, whose rt field is a source.
REQ-004 Port list (name, direction, width, meaning):
- clock  in  1: single clock, rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- opcode_FD  in  5: opcode in the F/D latch.
- rs_FD, rt_FD  in  5 each: source register fields in the F/D latch.
- opcode_DX  in  5: opcode in the D/X latch.
- rd_DX  in  5: destination register in the D/X latch.
- md_start  in  1: mult/div present in X this cycle.
- branch_taken_X  in  1: taken branch or jump resolved in X.
- stall_F, stall_D  out  1 each: hold the PC and the F/D latch.
- bubble_DX  out  1: load a nop into D/X on the next edge.
- hold_X  out  1: hold the D/X and X/M latches.
- flush_FD, flush_DX  out  1 each: squash the latch on the next edge.
- md_busy  out  1: mult/div in progress.
- md_done  out  1: one-cycle writeback strobe for a mult/div result.
- stall_cnt  out  16: saturating count of stall cycles.

Function
REQ-005 Load-use hazard (lu) is asserted when all hold: opcode_DX==LW_OP, rd_DX!=0, and either rd_DX==rs_FD or (opcode_FD==OP_RTYPE and rd_DX==rt_FD).
REQ-006 In IDLE with lu=1 and branch_taken_X=0, the block asserts stall_F=stall_D=bubble_DX=1 combinationally, for exactly one cycle per hazard.
REQ-007 When branch_taken_X=1, flush_FD=flush_DX=1 and stall_F/stall_D/bubble_DX=0; flush wins over lu in the same cycle.
REQ-008 FSM states are IDLE, MD_BUSY and MD_DONE.
REQ-009 IDLE to MD_BUSY on md_start=1; the down-counter loads MD_LATENCY-2.
REQ-010 In MD_BUSY:
- stall_F=stall_D=hold_X=1 and md_busy=1.
- The counter decrements each cycle.
- The FSM moves to MD_DONE when the counter is 0.
REQ-011 In MD_DONE, md_done=1 and md_busy=0 for one cycle, then IDLE. The stall, hold and bubble outputs are 0 in MD_DONE.
REQ-012 md_start is ignored outside IDLE.
REQ-013 md_start takes precedence over lu in IDLE.
REQ-014 branch_taken_X is ignored in MD_BUSY, because the mult/div occupies X.
REQ-015 Total occupancy: md_start asserted at edge N gives md_busy high for MD_LATENCY-1 cycles and md_done high exactly MD_LATENCY cycles after N.
REQ-016 A back-to-back md_start in MD_DONE is ignored; it re-triggers only once the FSM is in IDLE.
REQ-017 stall_cnt increments on every cycle in which stall_F=1 and saturates at 16'hFFFF without wrapping.
REQ-018 All outputs other than the counter, state and stall_cnt are combinational from the state and the inputs. There is no added latency.

Reset
REQ-019 reset_n=0 asynchronously forces:
- state to IDLE;
- the counter to 0;
- stall_cnt to 0;
- md_busy=md_done=0.
REQ-020 Reset asserted in MD_BUSY abandons the operation, and no md_done is produced afterwards.
REQ-021 While reset_n=0, every output is 0, including the combinational ones.
REQ-022 Reset deassertion takes effect at the first rising edge of clock after reset_n goes high.

Structure
REQ-023 A shared package pipe_pkg holds:
- the opcode constants (LW_OP, OP_RTYPE, mult/div ALU op);
- the FSM state enumeration;
- REG_W=5 and OP_W=5.
REQ-024 One sub-module, md_counter, holds the loadable down-counter with a zero flag.
REQ-025 Hazard detection stays inline in pipeline_ctrl.

Verification
REQ-026 Reset mid-MD: md_start, then reset_n=0 at cycle 5 -> state IDLE, md_busy=0, stall_cnt=0, no md_done afterwards.
REQ-027 Load-use: opcode_DX=01000, rd_DX=3, rs_FD=3 -> stall_F=stall_D=bubble_DX=1 for 1 cycle; with rd_DX=0 -> no stall.
REQ-028 rt case: opcode_FD=00000, rt_FD=7, rd_DX=7, opcode_DX=LW_OP -> stall; the same with opcode_FD=00101 (addi) -> no stall.
REQ-029 Flush priority: lu=1 and branch_taken_X=1 together -> flush_FD=flush_DX=1, stall_F=0, stall_cnt unchanged.
REQ-030 Mult/div with MD_LATENCY=32: md_start pulse -> md_busy high 31 cycles, md_done single pulse 32 cycles after start, stall_cnt=31; a second md_start during busy -> ignored.
REQ-031 Saturation: force more than 65535 stall cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared opcode constants, field widths and the mult/div FSM
//               state encoding for the pipeline hazard/stall controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   localparam int unsigned REG_W        = 5;   // register-specifier width
   localparam int unsigned OP_W         = 5;   // opcode width
   localparam int unsigned MD_CNT_W     = 6;   // holds MD_LATENCY-2 up to 62
   localparam int unsigned STALL_CNT_W  = 16;

   localparam logic [OP_W-1:0] C_LW_OP     = 5'b01000;
   localparam logic [OP_W-1:0] C_OP_RTYPE  = 5'b00000;
   localparam logic [OP_W-1:0] C_MD_ALU_OP = 5'b00110; // mult/div ALU op

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MD_BUSY = 2'd1,
      ST_MD_DONE = 2'd2
   } state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/md_counter.sv
`default_nettype none
// ============================================================================
// Module      : md_counter
// Description : Loadable down-counter with a zero flag, used to time the
//               mult/div occupancy of the execute stage. Stops at zero.
// Ports       : clock, reset_n   - clock / async active-low reset
//               load_i, load_val_i - synchronous load (wins over decrement)
//               dec_i            - decrement by one when non-zero
//               zero_o           - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module md_counter #(
   parameter int unsigned WIDTH = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule : md_counter
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Pipeline hazard and stall controller. Detects load-use
//               hazards, applies branch flushes, and sequences a multi-cycle
//               mult/div through IDLE -> MD_BUSY -> MD_DONE. Counts stall
//               cycles in a saturating counter.
// Ports       : clock, reset_n              - clock / async active-low reset
//               opcode_FD, rs_FD, rt_FD     - F/D latch fields
//               opcode_DX, rd_DX            - D/X latch fields
//               md_start, branch_taken_X    - execute-stage events
//               stall_F, stall_D, bubble_DX, hold_X, flush_FD, flush_DX
//                                           - pipeline control
//               md_busy, md_done            - mult/div status
//               stall_cnt                   - saturating stall-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned     MD_LATENCY = 32,        // legal range 2..64
   parameter logic [OP_W-1:0] LW_OP      = C_LW_OP,
   parameter logic [OP_W-1:0] OP_RTYPE   = C_OP_RTYPE
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [OP_W-1:0]        opcode_FD,
   input  logic [REG_W-1:0]       rs_FD,
   input  logic [REG_W-1:0]       rt_FD,
   input  logic [OP_W-1:0]        opcode_DX,
   input  logic [REG_W-1:0]       rd_DX,
   input  logic                   md_start,
   input  logic                   branch_taken_X,
   output logic                   stall_F,
   output logic                   stall_D,
   output logic                   bubble_DX,
   output logic                   hold_X,
   output logic                   flush_FD,
   output logic                   flush_DX,
   output logic                   md_busy,
   output logic                   md_done,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   // Busy phase runs count MD_LATENCY-2 .. 0 inclusive, i.e. MD_LATENCY-1
   // cycles, so MD_DONE lands MD_LATENCY cycles after the md_start cycle.
   localparam logic [MD_CNT_W-1:0] C_MD_LOAD = MD_CNT_W'(MD_LATENCY - 2);

   state_t state_q;
   state_t state_d;

   logic w_lu;
   logic w_cnt_load;
   logic w_cnt_dec;
   logic w_cnt_zero;
   logic w_stall;
   logic w_bubble;
   logic w_hold;
   logic w_flush;
   logic w_busy;
   logic w_done;

   logic [STALL_CNT_W-1:0] stall_cnt_q;
   logic [STALL_CNT_W-1:0] stall_cnt_d;

   // Load-use: a load in D/X writes a register the F/D instruction reads.
   // rt is only a source for R-type; r0 never creates a dependency.
   assign w_lu = (opcode_DX == LW_OP) && (rd_DX != '0) &&
                 ((rd_DX == rs_FD) || ((opcode_FD == OP_RTYPE) && (rd_DX == rt_FD)));

   always_comb begin
      state_d    = state_q;
      w_cnt_load = 1'b0;
      w_cnt_dec  = 1'b0;
      w_stall    = 1'b0;
      w_bubble   = 1'b0;
      w_hold     = 1'b0;
      w_flush    = 1'b0;
      w_busy     = 1'b0;
      w_done     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            w_flush = branch_taken_X;
            if (md_start) begin
               state_d    = ST_MD_BUSY;
               w_cnt_load = 1'b1;
            end else if (w_lu && !branch_taken_X) begin
               w_stall  = 1'b1;
               w_bubble = 1'b1;
            end
         end
         ST_MD_BUSY: begin
            // The mult/div owns X, so any branch_taken_X here is ignored.
            w_stall   = 1'b1;
            w_hold    = 1'b1;
            w_busy    = 1'b1;
            w_cnt_dec = 1'b1;
            if (w_cnt_zero) begin
               state_d = ST_MD_DONE;
            end
         end
         ST_MD_DONE: begin
            w_done  = 1'b1;
            w_flush = branch_taken_X;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   md_counter #(
      .WIDTH (MD_CNT_W)
   ) u_md_counter (
      .clock      (clock),
      .reset_n    (reset_n),
      .load_i     (w_cnt_load),
      .load_val_i (C_MD_LOAD),
      .dec_i      (w_cnt_dec),
      .zero_o     (w_cnt_zero)
   );

   // Combinational outputs are forced low while reset is held, since the
   // hazard term depends only on inputs and would otherwise leak through.
   assign stall_F   = reset_n & w_stall;
   assign stall_D   = reset_n & w_stall;
   assign bubble_DX = reset_n & w_bubble;
   assign hold_X    = reset_n & w_hold;
   assign flush_FD  = reset_n & w_flush;
   assign flush_DX  = reset_n & w_flush;
   assign md_busy   = reset_n & w_busy;
   assign md_done   = reset_n & w_done;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_F && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl: table of hazard/flush
//               vectors plus directed mult/div, reset and saturation runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;
   import pipe_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [4:0]  opcode_FD, rs_FD, rt_FD, opcode_DX, rd_DX;
   logic        md_start, branch_taken_X;
   logic        stall_F, stall_D, bubble_DX, hold_X, flush_FD, flush_DX;
   logic        md_busy, md_done;
   logic [15:0] stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   always #5 clock = ~clock;

   pipeline_ctrl dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .opcode_FD      (opcode_FD),
      .rs_FD          (rs_FD),
      .rt_FD          (rt_FD),
      .opcode_DX      (opcode_DX),
      .rd_DX          (rd_DX),
      .md_start       (md_start),
      .branch_taken_X (branch_taken_X),
      .stall_F        (stall_F),
      .stall_D        (stall_D),
      .bubble_DX      (bubble_DX),
      .hold_X         (hold_X),
      .flush_FD       (flush_FD),
      .flush_DX       (flush_DX),
      .md_busy        (md_busy),
      .md_done        (md_done),
      .stall_cnt      (stall_cnt)
   );

   typedef struct {
      logic [4:0] op_fd;
      logic [4:0] rs_fd;
      logic [4:0] rt_fd;
      logic [4:0] op_dx;
      logic [4:0] rd_dx;
      logic       br;
      logic       exp_stall;
      logic       exp_flush;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_in(input logic [4:0] ofd, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] odx, input logic [4:0] rd,
                         input logic ms, input logic br);
      opcode_FD = ofd; rs_FD = rs; rt_FD = rt;
      opcode_DX = odx; rd_DX = rd; md_start = ms; branch_taken_X = br;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
      exp_cnt = 0;
   endtask

   initial begin
      // {op_fd, rs, rt, op_dx, rd, branch, stall, flush}
      vecs[0] = '{5'b00101, 5'd3,  5'd0, 5'b01000, 5'd3,  1'b0, 1'b1, 1'b0}; // rs hit
      vecs[1] = '{5'b00101, 5'd0,  5'd0, 5'b01000, 5'd0,  1'b0, 1'b0, 1'b0}; // rd=r0
      vecs[2] = '{5'b00101, 5'd4,  5'd3, 5'b01000, 5'd3,  1'b0, 1'b0, 1'b0}; // rt not a source
      vecs[3] = '{5'b00000, 5'd1,  5'd7, 5'b01000, 5'd7,  1'b0, 1'b1, 1'b0}; // R-type rt hit
      vecs[4] = '{5'b00101, 5'd1,  5'd7, 5'b01000, 5'd7,  1'b0, 1'b0, 1'b0}; // addi rt
      vecs[5] = '{5'b00101, 5'd3,  5'd0, 5'b00000, 5'd3,  1'b0, 1'b0, 1'b0}; // not a load
      vecs[6] = '{5'b00101, 5'd3,  5'd0, 5'b01000, 5'd3,  1'b1, 1'b0, 1'b1}; // flush wins
      vecs[7] = '{5'b00101, 5'd1,  5'd2, 5'b00000, 5'd5,  1'b1, 1'b0, 1'b1}; // plain flush
      vecs[8] = '{5'b00000, 5'd9,  5'd2, 5'b01000, 5'd9,  1'b0, 1'b1, 1'b0}; // R-type rs hit
      vecs[9] = '{5'b00101, 5'd31, 5'd0, 5'b01000, 5'd31, 1'b0, 1'b1, 1'b0}; // r31

      // ---- reset state: hazard and branch present, every output must be 0
      reset_n = 1'b0;
      set_in(5'b00101, 5'd3, 5'd0, 5'b01000, 5'd3, 1'b0, 1'b1);
      #2;
      check("rst_stall_F",  {31'd0, stall_F},   32'd0);
      check("rst_bubble",   {31'd0, bubble_DX}, 32'd0);
      check("rst_flush",    {31'd0, flush_FD},  32'd0);
      check("rst_md_busy",  {31'd0, md_busy},   32'd0);
      check("rst_md_done",  {31'd0, md_done},   32'd0);
      repeat (2) step();
      check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      reset_n = 1'b1;
      set_in(5'b00101, 5'd0, 5'd0, 5'b00000, 5'd0, 1'b0, 1'b0);
      step();

      // ---- table vectors, one cycle each
      for (int i = 0; i < 10; i++) begin
         set_in(vecs[i].op_fd, vecs[i].rs_fd, vecs[i].rt_fd, vecs[i].op_dx,
                vecs[i].rd_dx, 1'b0, vecs[i].br);
         #1;
         check($sformatf("v%0d_stall_F", i),   {31'd0, stall_F},   {31'd0, vecs[i].exp_stall});
         check($sformatf("v%0d_stall_D", i),   {31'd0, stall_D},   {31'd0, vecs[i].exp_stall});
         check($sformatf("v%0d_bubble", i),    {31'd0, bubble_DX}, {31'd0, vecs[i].exp_stall});
         check($sformatf("v%0d_flush_FD", i),  {31'd0, flush_FD},  {31'd0, vecs[i].exp_flush});
         check($sformatf("v%0d_flush_DX", i),  {31'd0, flush_DX},  {31'd0, vecs[i].exp_flush});
         check($sformatf("v%0d_hold_X", i),    {31'd0, hold_X},    32'd0);
         if (vecs[i].exp_stall) exp_cnt++;
         step();
         check($sformatf("v%0d_stall_cnt", i), {16'd0, stall_cnt}, exp_cnt);
      end

      // ---- mult/div sequence, MD_LATENCY = 32
      do_reset();
      set_in(5'b00101, 5'd3, 5'd0, 5'b01000, 5'd3, 1'b1, 1'b0); // md_start with lu
      #1;
      check("md0_stall_F", {31'd0, stall_F},   32'd0);
      check("md0_bubble",  {31'd0, bubble_DX}, 32'd0);
      check("md0_busy",    {31'd0, md_busy},   32'd0);
      step();
      for (int k = 1; k <= 36; k++) begin
         set_in(5'b00101, 5'd1, 5'd2, 5'b00000, 5'd5,
                (k == 10) || (k == 32), (k == 5));
         #1;
         check($sformatf("md%0d_busy", k),    {31'd0, md_busy},  {31'd0, (k >= 1 && k <= 31)});
         check($sformatf("md%0d_done", k),    {31'd0, md_done},  {31'd0, (k == 32)});
         check($sformatf("md%0d_stall_F", k), {31'd0, stall_F},  {31'd0, (k >= 1 && k <= 31)});
         check($sformatf("md%0d_hold_X", k),  {31'd0, hold_X},   {31'd0, (k >= 1 && k <= 31)});
         check($sformatf("md%0d_flush", k),   {31'd0, flush_FD}, 32'd0);
         step();
      end
      check("md_stall_cnt", {16'd0, stall_cnt}, 32'd31);
      // retrigger from IDLE
      md_start = 1'b1;
      step();
      md_start = 1'b0;
      #1;
      check("md_retrigger_busy", {31'd0, md_busy}, 32'd1);

      // ---- reset in the middle of a mult/div
      do_reset();
      md_start = 1'b1;
      step();
      md_start = 1'b0;
      repeat (4) step();
      check("mid_busy_before", {31'd0, md_busy}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_busy",    {31'd0, md_busy},   32'd0);
      check("mid_rst_stall",   {31'd0, stall_F},   32'd0);
      check("mid_rst_cnt",     {16'd0, stall_cnt}, 32'd0);
      step();
      reset_n = 1'b1;
      begin
         int seen_done = 0;
         int seen_busy = 0;
         for (int k = 0; k < 40; k++) begin
            step();
            if (md_done) seen_done++;
            if (md_busy) seen_busy++;
         end
         check("mid_no_done", seen_done, 32'd0);
         check("mid_no_busy", seen_busy, 32'd0);
      end

      // ---- saturation: hold a load-use hazard continuously
      do_reset();
      set_in(5'b00101, 5'd3, 5'd0, 5'b01000, 5'd3, 1'b0, 1'b0);
      repeat (65534) step();
      check("sat_fffe", {16'd0, stall_cnt}, 32'h0000_FFFE);
      step();
      check("sat_ffff", {16'd0, stall_cnt}, 32'h0000_FFFF);
      repeat (10) step();
      check("sat_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
      check("sat_stall_F", {31'd0, stall_F}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pipeline_ctrl
`default_nettype wire
